// File: rtl/game_pkg.sv
// Shared types and constants for the board-game position controller and renderer glue.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    LAND = 2'd2,
    DONE = 2'd3
  } mover_state_t;

  typedef logic [3:0] tile_idx_t;
  typedef logic [9:0] pix_t;

  localparam int MAX_STEPS = 6;

  // Dice value 7 has no meaning on the board and is read as the largest roll.
  function automatic logic [2:0] sat_steps(input logic [2:0] raw);
    return (raw > 3'(MAX_STEPS)) ? 3'(MAX_STEPS) : raw;
  endfunction

endpackage

// File: rtl/hop_arc.sv
// Parabolic hop height: offset(f) = (f * (HOP_FRAMES - f)) >> HOP_SHIFT, formed in 12 bits.
module hop_arc
  import game_pkg::*;
#(
  parameter int HOP_FRAMES = 16,
  parameter int HOP_SHIFT  = 1
) (
  input  logic [5:0] f,
  output pix_t       offset
);

  logic [11:0] prod;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prod   = 12'(f) * (12'(HOP_FRAMES) - 12'(f));
    offset = pix_t'(prod >> HOP_SHIFT);
  end

endmodule

// File: rtl/player_mover.sv
// Tile-by-tile hop animator for the player sprite; outputs advance once per frame_tick.
// Optional PLAYER_BOUNCE_EN: overshooting the goal bounces back instead of clamping the roll.
module player_mover
  import game_pkg::*;
#(
  parameter int TILE_W      = 64,
  parameter int NUM_TILES   = 10,
  parameter int START_X     = 32,
  parameter int GROUND_Y    = 360,
  parameter int HOP_FRAMES  = 16,
  parameter int HOP_SHIFT   = 1,
  parameter int LAND_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_valid,
  input  logic [2:0] move_steps,
  output logic       move_ready,
  input  logic       home,
  output pix_t       player_x,
  output pix_t       player_y,
  output tile_idx_t  cur_tile,
  output logic       busy,
  output logic       done,
  output logic       at_goal
);

  localparam tile_idx_t GOAL     = tile_idx_t'(NUM_TILES - 1);
  localparam int        HOP_STEP = TILE_W / HOP_FRAMES;

  mover_state_t state;
  logic [5:0]   f;
  logic [5:0]   land_cnt;
  logic [2:0]   steps_left;
  logic         home_pend;
`ifdef PLAYER_BOUNCE_EN
  logic         backward;
`endif

  logic       accept;
  logic [2:0] start_steps;
  logic [5:0] f_next;
  pix_t       arc_off;
  pix_t       hop_dx;
  pix_t       hop_x;
  tile_idx_t  next_tile;

  function automatic pix_t tile_x(input tile_idx_t t);
    return pix_t'(START_X + int'(t) * TILE_W);
  endfunction

  hop_arc #(
    .HOP_FRAMES(HOP_FRAMES),
    .HOP_SHIFT (HOP_SHIFT)
  ) u_arc (
    .f     (f_next),
    .offset(arc_off)
  );

  always_comb begin
    accept = move_valid & move_ready;
    f_next = f + 6'd1;
    hop_dx = pix_t'(int'(f_next) * HOP_STEP);
`ifdef PLAYER_BOUNCE_EN
    start_steps = sat_steps(move_steps);
    next_tile   = backward ? (cur_tile - 4'd1) : (cur_tile + 4'd1);
    hop_x       = backward ? (tile_x(cur_tile) - hop_dx) : (tile_x(cur_tile) + hop_dx);
`else
    // The roll is cut down so the player never walks past the goal tile.
    start_steps = sat_steps(move_steps);
    if ({1'b0, start_steps} > (GOAL - cur_tile)) start_steps = 3'(GOAL - cur_tile);
    next_tile   = cur_tile + 4'd1;
    hop_x       = tile_x(cur_tile) + hop_dx;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      f          <= '0;
      land_cnt   <= '0;
      steps_left <= '0;
      home_pend  <= 1'b0;
      cur_tile   <= '0;
      player_x   <= pix_t'(START_X);
      player_y   <= pix_t'(GROUND_Y);
      move_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      at_goal    <= 1'b0;
`ifdef PLAYER_BOUNCE_EN
      backward   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            home_pend <= 1'b0;
            if (start_steps == 3'd0) begin
              done <= 1'b1;
            end else begin
              state      <= HOP;
              busy       <= 1'b1;
              move_ready <= 1'b0;
              steps_left <= start_steps;
              f          <= '0;
`ifdef PLAYER_BOUNCE_EN
              // Standing on the goal, the only legal direction is back down the track.
              backward   <= (cur_tile == GOAL);
`endif
            end
          end else if (frame_tick && (home || home_pend)) begin
            home_pend <= 1'b0;
            cur_tile  <= '0;
            player_x  <= pix_t'(START_X);
            player_y  <= pix_t'(GROUND_Y);
            at_goal   <= 1'b0;
          end else if (home) begin
            home_pend <= 1'b1;
          end
        end

        HOP: begin
          if (frame_tick) begin
            if (f_next == 6'(HOP_FRAMES)) begin
              // Landing snaps x to the tile grid, so no rounding ever accumulates.
              f          <= '0;
              land_cnt   <= '0;
              cur_tile   <= next_tile;
              player_x   <= tile_x(next_tile);
              player_y   <= pix_t'(GROUND_Y);
              steps_left <= steps_left - 3'd1;
              state      <= LAND;
`ifdef PLAYER_BOUNCE_EN
              if (next_tile == GOAL && steps_left != 3'd1) backward <= 1'b1;
`endif
            end else begin
              f        <= f_next;
              player_x <= hop_x;
              player_y <= pix_t'(GROUND_Y) - arc_off;
            end
          end
        end

        LAND: begin
          if (frame_tick) begin
            if (land_cnt == 6'(LAND_FRAMES - 1)) begin
              land_cnt <= '0;
              if (steps_left != 3'd0) begin
                state <= HOP;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              land_cnt <= land_cnt + 6'd1;
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          move_ready <= 1'b1;
          at_goal    <= (cur_tile == GOAL);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Randomized bench for player_mover against a path-level model; honours PLAYER_BOUNCE_EN.
module tb_player_mover;

  localparam int H    = 16;
  localparam int L    = 4;
  localparam int TW   = 64;
  localparam int NT   = 10;
  localparam int SX   = 32;
  localparam int GY   = 360;
  localparam int SH   = 1;
  localparam int STEP = TW / H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       move_valid;
  logic [2:0] move_steps;
  logic       move_ready;
  logic       home;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [3:0] cur_tile;
  logic       busy;
  logic       done;
  logic       at_goal;

  int n_tests = 0;
  int n_fail  = 0;
  int m_tile  = 0;
  int m_goal  = 0;

  player_mover dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .move_valid(move_valid),
    .move_steps(move_steps),
    .move_ready(move_ready),
    .home      (home),
    .player_x  (player_x),
    .player_y  (player_y),
    .cur_tile  (cur_tile),
    .busy      (busy),
    .done      (done),
    .at_goal   (at_goal)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame pulse after a random idle gap; optionally pokes move_valid to prove it is ignored.
  task automatic tick(input bit noise);
    repeat ($urandom_range(0, 2)) cyc();
    frame_tick = 1'b1;
    if (noise && $urandom_range(0, 5) == 0) begin
      move_valid = 1'b1;
      move_steps = 3'($urandom_range(0, 7));
    end
    cyc();
    frame_tick = 1'b0;
    move_valid = 1'b0;
  endtask

  function automatic int x_of(input int t);
    return SX + t * TW;
  endfunction

  function automatic int arc(input int f);
    return (f * (H - f)) >> SH;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, player_x, SX);
    check({tag, "_y"}, player_y, GY);
    check({tag, "_tile"}, cur_tile, 0);
    check({tag, "_ready"}, move_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_goal"}, at_goal, 0);
  endtask

  // Plays one dice roll. abort_after > 0 pulls reset right after that many ticks.
  task automatic do_move(input int req, input bit with_home, input int abort_after);
    int eff, k, dir, h, r, f, ex, ey;
    int path[$];
    eff = (req > 6) ? 6 : req;
`ifdef PLAYER_BOUNCE_EN
    k = eff;
`else
    k = (eff > NT - 1 - m_tile) ? NT - 1 - m_tile : eff;
`endif
    path.push_back(m_tile);
    dir = (m_tile == NT - 1) ? -1 : 1;
    for (int i = 0; i < k; i++) begin
      path.push_back(path[i] + dir);
      if (path[i + 1] == NT - 1) dir = -1;
    end

    move_valid = 1'b1;
    move_steps = 3'(req);
    home       = with_home;
    frame_tick = 1'($urandom_range(0, 1));
    cyc();
    move_valid = 1'b0;
    home       = 1'b0;
    frame_tick = 1'b0;

    if (k == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      cyc();
      check("zero_done_clr", done, 0);
      check("zero_busy2", busy, 0);
      check("zero_x", player_x, x_of(m_tile));
      check("zero_tile", cur_tile, m_tile);
      check("zero_goal", at_goal, m_goal);
      return;
    end

    check("acc_busy", busy, 1);
    check("acc_ready", move_ready, 0);
    check("acc_x", player_x, x_of(m_tile));

    for (int t = 1; t <= k * (H + L); t++) begin
      tick(1'b1);
      h = (t - 1) / (H + L);
      r = (t - 1) % (H + L) + 1;
      if (r < H) begin
        f  = r;
        ex = x_of(path[h]) + (path[h + 1] - path[h]) * f * STEP;
        ey = GY - arc(f);
      end else begin
        ex = x_of(path[h + 1]);
        ey = GY;
      end
      check("hop_x", player_x, ex);
      check("hop_y", player_y, ey);
      if (t == abort_after) begin
        rst_n = 1'b0;
        cyc();
        check_reset_vals("rst_mid");
        rst_n  = 1'b1;
        m_tile = 0;
        m_goal = 0;
        return;
      end
      if (t < k * (H + L)) check("early_done", done, 0);
    end

    check("done_pulse", done, 1);
    check("done_ready", move_ready, 0);
    cyc();
    m_tile = path[k];
    m_goal = (m_tile == NT - 1) ? 1 : 0;
    check("end_done_clr", done, 0);
    check("end_ready", move_ready, 1);
    check("end_busy", busy, 0);
    check("end_tile", cur_tile, m_tile);
    check("end_x", player_x, x_of(m_tile));
    check("end_y", player_y, GY);
    check("end_goal", at_goal, m_goal);
  endtask

  task automatic home_test();
    int seen_done;
    seen_done = 0;
    home = 1'b1;
    cyc();
    home = 1'b0;
    check("home_wait_x", player_x, x_of(m_tile));
    repeat ($urandom_range(0, 3)) begin
      cyc();
      seen_done |= int'(done);
    end
    check("home_wait_tile", cur_tile, m_tile);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    seen_done |= int'(done);
    m_tile = 0;
    m_goal = 0;
    check("home_x", player_x, SX);
    check("home_y", player_y, GY);
    check("home_tile", cur_tile, 0);
    check("home_goal", at_goal, 0);
    check("home_no_done", seen_done, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    move_valid = 1'b0;
    move_steps = 3'd0;
    home       = 1'b0;
    repeat (3) cyc();
    check_reset_vals("reset");
    rst_n = 1'b1;
    cyc();
    check_reset_vals("post_reset");

    do_move(3, 1'b0, -1);
    do_move(0, 1'b0, -1);
    home_test();
    do_move(3, 1'b0, 25);
    do_move(6, 1'b0, -1);
    do_move(1, 1'b0, -1);
    do_move(4, 1'b0, -1);
    do_move(7, 1'b0, -1);
    do_move(2, 1'b1, -1);

    for (int i = 0; i < 25; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) home_test();
      else do_move($urandom_range(0, 7), (r == 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_mover.md
# player_mover

Sequential position controller that drives the `player_x` / `player_y` inputs of the UI renderer. It accepts a dice-roll step count through a valid/ready handshake and animates the player tile-by-tile along a horizontal track. Each tile move is a parabolic hop, and all outputs advance once per video frame. It sits between the game-control FSM (dice result) and the pixel renderer.

## Interface
- `TILE_W`, 64: pixel pitch between tiles; must be divisible by `HOP_FRAMES`.
- `NUM_TILES`, 10: track length; tile `NUM_TILES-1` is the goal.
- `START_X`, 32: x of tile 0.
- `GROUND_Y`, 360: player y when standing.
- `HOP_FRAMES`, 16: frames per hop; power of two, ≤ 64.
- `HOP_SHIFT`, 1: arc scale; offset = (f·(HOP_FRAMES−f)) >> HOP_SHIFT.
- `LAND_FRAMES`, 4: idle frames after each landing.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame at start of vblank.
- `move_valid` in 1: step request present.
- `move_steps` in 3: steps 0..6; values 7 are treated as 6.
- `move_ready` out 1: high only in IDLE.
- `home` in 1: return to tile 0; honoured only in IDLE.
- `player_x` out 10: player pixel x.
- `player_y` out 10: player pixel y.
- `cur_tile` out 4: current or last-landed tile index.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: one-cycle pulse when a move completes.
- `at_goal` out 1: high in IDLE when `cur_tile == NUM_TILES-1`.

## Operation
- States:
  - IDLE → HOP on accept (`move_valid & move_ready`) with steps ≠ 0.
  - HOP → LAND when frame count f reaches `HOP_FRAMES`.
  - LAND → HOP if steps remain, otherwise → DONE after `LAND_FRAMES` ticks.
  - DONE → IDLE after one cycle, pulsing `done`.
- Accept with steps = 0: no motion; `done` pulses on the next cycle; state stays in IDLE.
- Accept latches the remaining-step count and direction (forward). `move_steps` is sampled only on the accept cycle.
- HOP, per `frame_tick`:
  - f increments.
  - `player_x` moves ±`TILE_W/HOP_FRAMES`.
  - `player_y = GROUND_Y − arc(f)`.
- When f reaches `HOP_FRAMES`: y = `GROUND_Y`, `cur_tile` ±1, remaining steps −1, f cleared.
- Overshoot without the config macro: the step count is clamped at accept to `NUM_TILES-1-cur_tile`. A clamp to 0 behaves as the zero-step case.
- `home` in IDLE: on the next `frame_tick`, `cur_tile` = 0, `player_x` = `START_X`, `player_y` = `GROUND_Y`; `done` is not pulsed. If `home` and an accept occur in the same cycle, the accept wins and `home` is dropped.
- `move_valid` while busy is ignored; no queuing.
- Arithmetic:
  - arc computed in 12 bits, then truncated to 10.
  - `player_x` is always exactly `START_X + cur_tile·TILE_W ± f·TILE_W/HOP_FRAMES`, with no accumulated drift.

## Timing
- Reset values: `cur_tile` = 0, `player_x` = `START_X`, `player_y` = `GROUND_Y`, `move_ready` = 1, `busy` = 0, `done` = 0, `at_goal` = 0; state is IDLE and f = 0.
- Reset mid-hop restores all of the above on the first clock edge with `rst_n` low.
- Accept at edge N: at edge N+1, state = HOP, `busy` = 1, `move_ready` = 0.
- A `frame_tick` in the accept cycle itself does not advance f.
- Position outputs are registered and change only on the clock edge that samples `frame_tick`. They are stable for a whole frame, so there is no tearing.
- Move of k steps, from accept to `done`: k·(`HOP_FRAMES`+`LAND_FRAMES`) frame ticks plus 2 clocks.
- `move_ready` rises on the cycle after `done`.
- `at_goal` is updated in the same cycle that IDLE is entered.

## Configuration
- `PLAYER_BOUNCE_EN` defined:
  - No clamp at accept.
  - On landing at the goal with steps remaining, direction flips to backward and hops continue with −x.
  - `cur_tile` decrements on backward landings.
  - `at_goal` is set only if the move ends on the goal tile.
- `PLAYER_BOUNCE_EN` undefined: clamping behaviour as described in Operation; the direction flop and the backward datapath are compiled out.

## Structure
- The shared package `game_pkg` holds:
  - `mover_state_t` enum (IDLE, HOP, LAND, DONE).
  - `tile_idx_t` (4-bit) and `pix_t` (10-bit) typedefs.
  - `MAX_STEPS` = 6.
- One sub-module, `hop_arc`: a combinational function of f (6-bit) that outputs the y offset (10-bit) from `HOP_FRAMES` and `HOP_SHIFT`. The FSM and registers stay in `player_mover`.

## Test plan
- Reset release → x = 32, y = 360, `cur_tile` = 0, `move_ready` = 1, `at_goal` = 0.
- From tile 0, accept steps = 3 → after 8 ticks x = 64, y = 328. After 60 ticks plus 2 clocks: `done` pulse, x = 224, y = 360, `cur_tile` = 3.
- Accept steps = 0 → `done` next cycle, `busy` never set, position unchanged. A `move_valid` pulse while busy → ignored, final tile unaffected.
- From tile 7, steps = 4:
  - macro off: ends at tile 9, x = 608, `at_goal` = 1, 40 ticks.
  - `PLAYER_BOUNCE_EN` on: hops to 9 then back to 7, x = 480, `at_goal` = 0, 80 ticks.
- `rst_n` low at f = 5 of the second hop → next edge shows the full reset values. Later, `home` in IDLE at tile 3 → the next tick gives x = 32, `cur_tile` = 0, with no `done`.
